// File: rtl/dcache_port_arbiter.sv
// Two-port D-cache arbiter (MEM stage = 0, page-table walker = 1); DCACHE_ARB_ROUND_ROBIN_EN selects round-robin ties, else requester 1 wins.
// Latency: request sampled in IDLE drives dc_en the next cycle; response passes through combinationally on completion.
// Backpressure: one transaction in flight; requests wait in IDLE, are held off during BUSY and the one-cycle DRAIN.
module dcache_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  r0_en,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic                  r0_write_en,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic [1:0]            r0_wlen,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_rvalid,
  output logic                  r0_write_done,
  output logic                  r0_page_fault,
  input  logic                  r1_en,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic                  r1_write_en,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic [1:0]            r1_wlen,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_rvalid,
  output logic                  r1_write_done,
  output logic                  r1_page_fault,
  output logic                  dc_en,
  output logic [ADDR_WIDTH-1:0] dc_in_addr,
  output logic                  dc_write_en,
  output logic [DATA_WIDTH-1:0] dc_in_wdata,
  output logic [1:0]            dc_in_wlen,
  input  logic [DATA_WIDTH-1:0] dc_out_rdata,
  input  logic                  dc_out_rvalid,
  input  logic                  dc_out_write_done,
  input  logic                  dc_out_page_fault,
  output logic                  busy,
  output logic                  grant_id
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state;
  logic                  owner;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_write_en;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [1:0]            lat_wlen;
  logic                  sel;
  logic                  owner_en;
  logic                  deliver;
  logic                  d0;
  logic                  d1;

`ifdef DCACHE_ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    sel = r1_en;
    if (r0_en && r1_en) sel = ~last_grant;
  end
`else
  // Requester 1 alone or in a tie wins; requester 0 only when it is alone.
  always_comb begin
    sel = r1_en;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      lat_addr     <= '0;
      lat_write_en <= 1'b0;
      lat_wdata    <= '0;
      lat_wlen     <= 2'd0;
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (r0_en || r1_en) begin
            state        <= BUSY;
            owner        <= sel;
            lat_addr     <= sel ? r1_addr     : r0_addr;
            lat_write_en <= sel ? r1_write_en : r0_write_en;
            lat_wdata    <= sel ? r1_wdata    : r0_wdata;
            lat_wlen     <= sel ? r1_wlen     : r0_wlen;
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
            last_grant   <= sel;
`endif
          end
        end
        BUSY: begin
          if (dc_out_rvalid || dc_out_write_done) state <= DRAIN;
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign grant_id    = owner;
  assign dc_en       = (state == BUSY);
  assign dc_in_addr  = lat_addr;
  assign dc_write_en = lat_write_en;
  assign dc_in_wdata = lat_wdata;
  assign dc_in_wlen  = lat_wlen;

  // A dropped enable (trap/flush) lets the cache finish but swallows the response.
  assign owner_en = owner ? r1_en : r0_en;
  assign deliver  = dc_en && (dc_out_rvalid || dc_out_write_done) && owner_en;
  assign d0       = deliver && !owner;
  assign d1       = deliver && owner;

  assign r0_rvalid     = d0 && dc_out_rvalid;
  assign r0_write_done = d0 && dc_out_write_done;
  assign r0_page_fault = d0 && dc_out_page_fault;
  assign r0_rdata      = d0 ? dc_out_rdata : '0;
  assign r1_rvalid     = d1 && dc_out_rvalid;
  assign r1_write_done = d1 && dc_out_write_done;
  assign r1_page_fault = d1 && dc_out_page_fault;
  assign r1_rdata      = d1 ? dc_out_rdata : '0;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed self-checking bench for dcache_port_arbiter; tie-break expectations follow DCACHE_ARB_ROUND_ROBIN_EN.
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        r0_en, r0_write_en, r1_en, r1_write_en;
  logic [63:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [1:0]  r0_wlen, r1_wlen;
  logic [63:0] r0_rdata, r1_rdata;
  logic        r0_rvalid, r0_write_done, r0_page_fault;
  logic        r1_rvalid, r1_write_done, r1_page_fault;
  logic        dc_en, dc_write_en;
  logic [63:0] dc_in_addr, dc_in_wdata;
  logic [1:0]  dc_in_wlen;
  logic [63:0] dc_out_rdata;
  logic        dc_out_rvalid, dc_out_write_done, dc_out_page_fault;
  logic        busy, grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .r0_en(r0_en), .r0_addr(r0_addr), .r0_write_en(r0_write_en), .r0_wdata(r0_wdata), .r0_wlen(r0_wlen),
    .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid), .r0_write_done(r0_write_done), .r0_page_fault(r0_page_fault),
    .r1_en(r1_en), .r1_addr(r1_addr), .r1_write_en(r1_write_en), .r1_wdata(r1_wdata), .r1_wlen(r1_wlen),
    .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid), .r1_write_done(r1_write_done), .r1_page_fault(r1_page_fault),
    .dc_en(dc_en), .dc_in_addr(dc_in_addr), .dc_write_en(dc_write_en), .dc_in_wdata(dc_in_wdata), .dc_in_wlen(dc_in_wlen),
    .dc_out_rdata(dc_out_rdata), .dc_out_rvalid(dc_out_rvalid), .dc_out_write_done(dc_out_write_done),
    .dc_out_page_fault(dc_out_page_fault), .busy(busy), .grant_id(grant_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r0_en = 0; r0_addr = '0; r0_write_en = 0; r0_wdata = '0; r0_wlen = 0;
    r1_en = 0; r1_addr = '0; r1_write_en = 0; r1_wdata = '0; r1_wlen = 0;
    dc_out_rdata = '0; dc_out_rvalid = 0; dc_out_write_done = 0; dc_out_page_fault = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    repeat (2) tick();
    n_checks++; if (dc_en !== 1'b0) begin n_fail++; $display("FAIL reset_dc_en got %b want 0", dc_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id got %b want 0", grant_id); end
    n_checks++; if (dc_in_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", dc_in_addr); end
    n_checks++; if ({r0_rvalid, r0_write_done, r0_page_fault, r1_rvalid, r1_write_done, r1_page_fault} !== 6'b0)
      begin n_fail++; $display("FAIL reset_resp got %b want 000000",
        {r0_rvalid, r0_write_done, r0_page_fault, r1_rvalid, r1_write_done, r1_page_fault}); end
    reset_n = 1;
    tick();
  endtask

  task automatic test_read();
    r0_en = 1; r0_addr = 64'h1000; r0_wlen = 3; r0_write_en = 0;
    #1;
    n_checks++; if (dc_en !== 1'b0) begin n_fail++; $display("FAIL read_pre_dc_en got %b want 0", dc_en); end
    tick();
    n_checks++; if (dc_en !== 1'b1) begin n_fail++; $display("FAIL read_dc_en got %b want 1", dc_en); end
    n_checks++; if (dc_in_addr !== 64'h1000) begin n_fail++; $display("FAIL read_addr got %h want 1000", dc_in_addr); end
    n_checks++; if (dc_in_wlen !== 2'd3) begin n_fail++; $display("FAIL read_wlen got %0d want 3", dc_in_wlen); end
    n_checks++; if (dc_write_en !== 1'b0) begin n_fail++; $display("FAIL read_write_en got %b want 0", dc_write_en); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL read_grant got %b want 0", grant_id); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL read_busy got %b want 1", busy); end
    r0_addr = 64'hFFFF;
    repeat (3) tick();
    n_checks++; if (dc_in_addr !== 64'h1000) begin n_fail++; $display("FAIL read_addr_held got %h want 1000", dc_in_addr); end
    n_checks++; if (r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL read_early_rvalid got %b want 0", r0_rvalid); end
    dc_out_rvalid = 1; dc_out_rdata = 64'hDEADBEEF;
    #1;
    n_checks++; if (r0_rvalid !== 1'b1) begin n_fail++; $display("FAIL read_rvalid got %b want 1", r0_rvalid); end
    n_checks++; if (r0_rdata !== 64'hDEADBEEF) begin n_fail++; $display("FAIL read_rdata got %h want deadbeef", r0_rdata); end
    n_checks++; if ({r1_rvalid, r1_rdata} !== 65'h0) begin n_fail++; $display("FAIL read_r1_quiet got %b/%h want 0", r1_rvalid, r1_rdata); end
    tick();
    n_checks++; if ({busy, dc_en} !== 2'b10) begin n_fail++; $display("FAIL read_drain busy/dc_en got %b want 10", {busy, dc_en}); end
    n_checks++; if (r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL read_drain_rvalid got %b want 0", r0_rvalid); end
    dc_out_rvalid = 0; r0_en = 0;
    tick();
    n_checks++; if ({busy, dc_en} !== 2'b00) begin n_fail++; $display("FAIL read_idle busy/dc_en got %b want 00", {busy, dc_en}); end
  endtask

  task automatic test_write();
    r1_en = 1; r1_write_en = 1; r1_addr = 64'h2008; r1_wdata = 64'h55; r1_wlen = 0;
    tick();
    n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL wr_grant got %b want 1", grant_id); end
    n_checks++; if ({dc_en, dc_write_en} !== 2'b11) begin n_fail++; $display("FAIL wr_dc_en/we got %b want 11", {dc_en, dc_write_en}); end
    n_checks++; if (dc_in_addr !== 64'h2008) begin n_fail++; $display("FAIL wr_addr got %h want 2008", dc_in_addr); end
    n_checks++; if (dc_in_wdata !== 64'h55) begin n_fail++; $display("FAIL wr_wdata got %h want 55", dc_in_wdata); end
    n_checks++; if (dc_in_wlen !== 2'd0) begin n_fail++; $display("FAIL wr_wlen got %0d want 0", dc_in_wlen); end
    dc_out_write_done = 1;
    #1;
    n_checks++; if ({r1_write_done, r0_write_done, r1_rvalid} !== 3'b100)
      begin n_fail++; $display("FAIL wr_done r1/r0/rv got %b want 100", {r1_write_done, r0_write_done, r1_rvalid}); end
    tick();
    dc_out_write_done = 0;
    #1;
    n_checks++; if ({dc_en, r1_write_done} !== 2'b00) begin n_fail++; $display("FAIL wr_drain dc_en/done got %b want 00", {dc_en, r1_write_done}); end
    tick();
    r1_en = 0; r1_write_en = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle_busy got %b want 0", busy); end
    tick();
    n_checks++; if ({dc_en, busy} !== 2'b00) begin n_fail++; $display("FAIL wr_no_regrant dc_en/busy got %b want 00", {dc_en, busy}); end
  endtask

  task automatic test_tie();
    logic first;
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    reset_n = 0; #1; reset_n = 1;
    clear_inputs();
    r0_en = 1; r0_addr = 64'hA0; r1_en = 1; r1_addr = 64'hB0;
    tick();
    n_checks++; if (grant_id !== first) begin n_fail++; $display("FAIL tie_first_grant got %b want %b", grant_id, first); end
    n_checks++; if (dc_in_addr !== (first ? 64'hB0 : 64'hA0)) begin n_fail++; $display("FAIL tie_first_addr got %h", dc_in_addr); end
    dc_out_rvalid = 1; dc_out_rdata = 64'h11;
    #1;
    n_checks++; if ({r0_rvalid, r1_rvalid} !== (first ? 2'b01 : 2'b10))
      begin n_fail++; $display("FAIL tie_first_resp r0/r1 got %b", {r0_rvalid, r1_rvalid}); end
    tick();
    dc_out_rvalid = 0;
    if (first) r1_en = 0; else r0_en = 0;
    tick();
    tick();
    n_checks++; if (grant_id !== ~first) begin n_fail++; $display("FAIL tie_second_grant got %b want %b", grant_id, ~first); end
    n_checks++; if (dc_in_addr !== (first ? 64'hA0 : 64'hB0)) begin n_fail++; $display("FAIL tie_second_addr got %h", dc_in_addr); end
    dc_out_rvalid = 1; dc_out_rdata = 64'h22;
    #1;
    n_checks++; if ({r0_rvalid, r1_rvalid} !== (first ? 2'b10 : 2'b01))
      begin n_fail++; $display("FAIL tie_second_resp r0/r1 got %b", {r0_rvalid, r1_rvalid}); end
    tick();
    dc_out_rvalid = 0; r0_en = 0; r1_en = 0;
    tick();
  endtask

  task automatic test_abort();
    r0_en = 1; r0_addr = 64'h300;
    tick();
    r0_en = 0; r1_en = 1; r1_addr = 64'h400;
    #1;
    n_checks++; if ({dc_en, grant_id} !== 2'b10) begin n_fail++; $display("FAIL abort_busy dc_en/grant got %b want 10", {dc_en, grant_id}); end
    repeat (3) tick();
    dc_out_rvalid = 1; dc_out_rdata = 64'h33;
    #1;
    n_checks++; if ({r0_rvalid, r1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL abort_discard r0/r1 got %b want 00", {r0_rvalid, r1_rvalid}); end
    n_checks++; if (r0_rdata !== 64'h0) begin n_fail++; $display("FAIL abort_rdata got %h want 0", r0_rdata); end
    tick();
    dc_out_rvalid = 0;
    n_checks++; if ({busy, dc_en} !== 2'b10) begin n_fail++; $display("FAIL abort_drain busy/dc_en got %b want 10", {busy, dc_en}); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle busy got %b want 0", busy); end
    tick();
    n_checks++; if ({dc_en, grant_id} !== 2'b11) begin n_fail++; $display("FAIL abort_next_grant dc_en/grant got %b want 11", {dc_en, grant_id}); end
    n_checks++; if (dc_in_addr !== 64'h400) begin n_fail++; $display("FAIL abort_next_addr got %h want 400", dc_in_addr); end
    dc_out_rvalid = 1;
    #1;
    n_checks++; if (r1_rvalid !== 1'b1) begin n_fail++; $display("FAIL abort_r1_rvalid got %b want 1", r1_rvalid); end
    tick();
    dc_out_rvalid = 0; r1_en = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    r1_en = 1; r1_addr = 64'h500;
    tick();
    n_checks++; if ({dc_en, grant_id} !== 2'b11) begin n_fail++; $display("FAIL rstmid_busy dc_en/grant got %b want 11", {dc_en, grant_id}); end
    reset_n = 0;
    #1;
    n_checks++; if ({dc_en, busy, grant_id} !== 3'b000)
      begin n_fail++; $display("FAIL rstmid_async dc_en/busy/grant got %b want 000", {dc_en, busy, grant_id}); end
    reset_n = 1; r1_en = 0;
    dc_out_rvalid = 1;
    #1;
    n_checks++; if ({r0_rvalid, r1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rstmid_late_rvalid got %b want 00", {r0_rvalid, r1_rvalid}); end
    tick();
    n_checks++; if ({busy, dc_en} !== 2'b00) begin n_fail++; $display("FAIL rstmid_idle busy/dc_en got %b want 00", {busy, dc_en}); end
    dc_out_rvalid = 0;
    tick();
  endtask

  task automatic test_page_fault();
    r0_en = 1; r0_write_en = 1; r0_addr = 64'h600; r0_wdata = 64'h77; r0_wlen = 2;
    tick();
    dc_out_write_done = 1; dc_out_page_fault = 1;
    #1;
    n_checks++; if ({r0_write_done, r0_page_fault} !== 2'b11) begin n_fail++; $display("FAIL pf_r0 done/pf got %b want 11", {r0_write_done, r0_page_fault}); end
    n_checks++; if ({r1_write_done, r1_page_fault, r1_rvalid} !== 3'b000)
      begin n_fail++; $display("FAIL pf_r1_quiet got %b want 000", {r1_write_done, r1_page_fault, r1_rvalid}); end
    tick();
    dc_out_write_done = 0; dc_out_page_fault = 0; r0_en = 0; r0_write_en = 0;
    #1;
    n_checks++; if (r0_page_fault !== 1'b0) begin n_fail++; $display("FAIL pf_drain got %b want 0", r0_page_fault); end
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_tie();
    test_abort();
    test_reset_mid();
    test_page_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
